// File: rtl/enum_seq.sv
// enum_seq: parameterised up/down state sequencer with dwell count, wrap pulse and illegal-load detection
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - advance enable
//   dir      - step direction, 0 up / 1 down (used only when BIDIR=1)
//   load     - synchronous load strobe, has priority over en
//   load_val - state to load; out-of-range values load RESET_STATE
//   clr_err  - clears the sticky error flag (a same-cycle set wins)
//   state    - current state, registered, always < N_STATES
//   wrap     - one-cycle pulse on the cycle the state wraps
//   illegal  - one-cycle pulse on an out-of-range load
//   err      - sticky illegal-load flag
//   at_last  - combinational, high when state == N_STATES-1
module enum_seq #(
    parameter int N_STATES    = 5,
    parameter int DWELL       = 1,
    parameter int RESET_STATE = 0,
    parameter int WRAP_TO     = 0,
    parameter int BIDIR       = 0,
    localparam int W  = N_STATES > 2 ? $clog2(N_STATES) : 1,
    localparam int DW = DWELL > 2 ? $clog2(DWELL) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr_err,
    output logic [W-1:0] state,
    output logic         wrap,
    output logic         illegal,
    output logic         err,
    output logic         at_last
);
    localparam logic [W-1:0]  LAST   = W'(N_STATES - 1);
    localparam logic [W-1:0]  RST_S  = W'(RESET_STATE);
    localparam logic [W-1:0]  WRAP_S = W'(WRAP_TO);
    localparam logic [DW-1:0] DLAST  = DW'(DWELL - 1);
    logic [DW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  state_nxt;
    logic          wrap_nxt, illegal_nxt, bad, step, down;
    assign bad     = load_val > LAST;
    assign step    = en && cnt == DLAST;
    assign down    = (BIDIR != 0) && dir;
    assign at_last = state == LAST;
    // Wrap is decided explicitly at both ends so a power-of-two N_STATES never relies on rollover.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wrap_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        if (load) begin
            cnt_nxt     = '0;
            state_nxt   = bad ? RST_S : load_val;
            illegal_nxt = bad;
        end else if (en) begin
            cnt_nxt = step ? '0 : cnt + 1'b1;
            if (step && down) begin
                state_nxt = state == '0 ? LAST : state - 1'b1;
                wrap_nxt  = state == '0;
            end else if (step) begin
                state_nxt = state == LAST ? WRAP_S : state + 1'b1;
                wrap_nxt  = state == LAST;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_S;
            cnt     <= '0;
            wrap    <= 1'b0;
            illegal <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wrap    <= wrap_nxt;
            illegal <= illegal_nxt;
            err     <= illegal_nxt | (err & ~clr_err);
        end
    end
endmodule

// File: doc/enum_seq.md
ENUM_SEQ -- requirements
Module: enum_seq

Interface
REQ-001 The module SHALL have parameter N_STATES, default 5, meaning number of legal states, 2..16.
REQ-002 The module SHALL have parameter DWELL, default 1, meaning enabled cycles spent in each state before advancing, 1..255.
REQ-003 The module SHALL have parameter RESET_STATE, default 0, meaning state after reset or illegal load; must be less than N_STATES.
REQ-004 The module SHALL have parameter WRAP_TO, default 0, meaning state entered after N_STATES-1 when stepping up; must be less than N_STATES.
REQ-005 The module SHALL have parameter BIDIR, default 0, meaning 1 enables down-stepping via dir, 0 ignores dir.
REQ-006 The module SHALL define W = max(1, clog2(N_STATES)) and DW = max(1, clog2(DWELL)) as derived widths.
REQ-007 The module SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 The module SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-009 The module SHALL have port en, input, 1, advance enable.
REQ-010 The module SHALL have port dir, input, 1, step direction: 0 up, 1 down.
REQ-011 The module SHALL have port load, input, 1, synchronous load strobe.
REQ-012 The module SHALL have port load_val, input, W, state to load.
REQ-013 The module SHALL have port clr_err, input, 1, clears sticky error.
REQ-014 The module SHALL have port state, output, W, current state, registered.
REQ-015 The module SHALL have port wrap, output, 1, one-cycle pulse on the cycle state wraps, registered.
REQ-016 The module SHALL have port illegal, output, 1, one-cycle pulse on an out-of-range load, registered.
REQ-017 The module SHALL have port err, output, 1, sticky illegal-load flag, registered.
REQ-018 The module SHALL have port at_last, output, 1, combinational, high when state == N_STATES-1.

Function
REQ-019 The module SHALL apply this per-cycle priority: load, then en, then hold.
REQ-020 The module SHALL, with en=1 and load=0, increment the dwell counter, and SHALL step state and return the dwell counter to 0 when the counter equals DWELL-1; DWELL=1 SHALL step every enabled cycle.
REQ-021 The module SHALL, when en=0 and load=0, hold both state and dwell counter; a partial dwell SHALL resume rather than restart.
REQ-022 The module SHALL, when stepping up (dir=0 or BIDIR=0), go to state+1, except that from N_STATES-1 it SHALL go to WRAP_TO with wrap=1 for that cycle.
REQ-023 The module SHALL, when stepping down (dir=1 and BIDIR=1), go to state-1, except that from 0 it SHALL go to N_STATES-1 with wrap=1 for that cycle.
REQ-024 The module SHALL sample dir only on the stepping cycle; a dir change mid-dwell SHALL not reset the dwell counter.
REQ-025 The module SHALL, on load with load_val < N_STATES, set state=load_val and dwell counter=0, with no wrap or illegal pulse.
REQ-026 The module SHALL, on load with load_val >= N_STATES, set state=RESET_STATE and dwell counter=0, pulse illegal for one cycle and set err.
REQ-027 The module SHALL ensure state never holds a value >= N_STATES.
REQ-028 The module SHALL clear err on clr_err=1; when set and clear occur in the same cycle, set SHALL win.
REQ-029 The module SHALL keep wrap and illegal low on every cycle not named above.
REQ-030 The module SHALL compute state arithmetic at W bits without intermediate overflow; N_STATES a power of 2 SHALL still use the explicit wrap rule, not natural rollover.

Reset
REQ-031 The module SHALL, while rst_n=0, immediately force state=RESET_STATE, dwell counter=0, wrap=0, illegal=0 and err=0, regardless of clk.
REQ-032 The module SHALL, on reset assertion mid-dwell or mid-load, abandon the operation; the first enabled cycle after release SHALL start a fresh dwell.
REQ-033 The module SHALL ignore en, load and clr_err on the cycle rst_n deasserts only if that deassertion is not synchronised to clk; integration SHALL provide synchronised release.

Verification
REQ-034 The bench SHALL cover defaults (N=5, DWELL=1, WRAP_TO=0) with en=1 for 6 cycles -> state 0,1,2,3,4,0, wrap high on the 4->0 cycle only, at_last high while state=4.
REQ-035 The bench SHALL cover N=5, DWELL=3, WRAP_TO=2 with en=1 -> each state held 3 cycles, and 4 steps to 2 with wrap; dropping en for 2 cycles mid-dwell SHALL extend that state by exactly 2 cycles.
REQ-036 The bench SHALL cover BIDIR=1 from state 0 with dir=1 -> state 4 with wrap, then 3; with BIDIR=0 and dir=1 -> state steps up to 1.
REQ-037 The bench SHALL cover load_val=3 together with en=1 -> state=3, no wrap; load_val=6 -> state=RESET_STATE, illegal pulse, err=1 held until clr_err; load_val=7 with clr_err in the same cycle -> err remains 1.
REQ-038 The bench SHALL cover N=4 stepping up from 3 -> state goes to WRAP_TO, not 0 unless WRAP_TO=0; randomised en/dir/load for 10k cycles SHALL show state < N_STATES on every cycle.
REQ-039 The bench SHALL cover rst_n pulsed low between clock edges mid-dwell -> outputs at reset values before the next edge, and the full dwell restarts after release.
